// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
// Holds the FSM state encoding, the oversampling factor and the parity mode codes.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, 16x oversampled, configurable data bits, stop bits and parity.
// Ports: i_clk clock; i_reset_n async active-low reset; i_tick 16x baud enable;
//   i_tx_start/i_tx_data send request and byte; o_tx serial line (idle high);
//   o_tx_busy high while a frame is in progress; o_tx_done one-cycle end-of-frame pulse.
module uart_tx
    import uart_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_STOP = 1,
    parameter int PARITY  = PAR_NONE
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_tick,
    input  logic               i_tx_start,
    input  logic [NB_DATA-1:0] i_tx_data,
    output logic               o_tx,
    output logic               o_tx_busy,
    output logic               o_tx_done
);

    localparam int NB_BIT = $clog2(NB_DATA + 1);
    localparam logic [4:0] LAST_TICK = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] LAST_STOP = 5'(OVERSAMPLE * NB_STOP - 1);
    localparam logic [NB_BIT-1:0] LAST_BIT = NB_BIT'(NB_DATA - 1);

    state_t             state, state_next;
    logic [4:0]         tick_cnt, tick_next;
    logic [NB_BIT-1:0]  bit_cnt, bit_next;
    logic [NB_DATA-1:0] shreg, shreg_next;
    logic               par, par_next, tx_next, done_next;

    assign o_tx_busy = state != ST_IDLE;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= ST_IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            par       <= 1'b0;
            o_tx      <= 1'b1;
            o_tx_done <= 1'b0;
        end else begin
            state     <= state_next;
            tick_cnt  <= tick_next;
            bit_cnt   <= bit_next;
            shreg     <= shreg_next;
            par       <= par_next;
            o_tx      <= tx_next;
            o_tx_done <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        tick_next  = tick_cnt;
        bit_next   = bit_cnt;
        shreg_next = shreg;
        par_next   = par;
        done_next  = 1'b0;
        case (state)
            ST_IDLE: if (i_tx_start) begin
                state_next = ST_START;
                tick_next  = '0;
                bit_next   = '0;
                shreg_next = i_tx_data;
                // parity is fixed at latch time since the shift register is consumed
                par_next   = ^i_tx_data ^ (PARITY == PAR_ODD);
            end
            ST_START: if (i_tick) begin
                tick_next = tick_cnt == LAST_TICK ? 5'd0 : tick_cnt + 5'd1;
                if (tick_cnt == LAST_TICK) state_next = ST_DATA;
            end
            ST_DATA: if (i_tick) begin
                tick_next = tick_cnt == LAST_TICK ? 5'd0 : tick_cnt + 5'd1;
                if (tick_cnt == LAST_TICK) begin
                    shreg_next = shreg >> 1;
                    bit_next   = bit_cnt + NB_BIT'(1);
                    if (bit_cnt == LAST_BIT) state_next = PARITY != PAR_NONE ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: if (i_tick) begin
                tick_next = tick_cnt == LAST_TICK ? 5'd0 : tick_cnt + 5'd1;
                if (tick_cnt == LAST_TICK) state_next = ST_STOP;
            end
            ST_STOP: if (i_tick) begin
                tick_next = tick_cnt == LAST_STOP ? 5'd0 : tick_cnt + 5'd1;
                if (tick_cnt == LAST_STOP) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                tick_next  = '0;
                bit_next   = '0;
            end
        endcase
        // the line is driven from the state being entered so o_tx stays a pure register
        tx_next = state_next == ST_START  ? 1'b0 :
                  state_next == ST_DATA   ? shreg_next[0] :
                  state_next == ST_PARITY ? par_next : 1'b1;
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx in four configurations (8N1, even, odd, 8N2).
// The line is sampled on every tick and compared with frames built from bit-level rules.
module tb_uart_tx;

    typedef bit bq_t[$];

    logic       clk = 0;
    logic       rst_n = 1;
    logic       tick;
    logic [3:0] start = '0;
    logic [7:0] data = '0;
    logic [3:0] tx, busy, done;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    bit         samp[4][$];
    int         dq[4][$];
    int         base[4];
    int         dbase[4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign tick = cyc[1:0] == 2'b11;

    uart_tx #(.NB_DATA(8), .NB_STOP(1), .PARITY(0)) u0 (.i_clk(clk), .i_reset_n(rst_n), .i_tick(tick),
        .i_tx_start(start[0]), .i_tx_data(data), .o_tx(tx[0]), .o_tx_busy(busy[0]), .o_tx_done(done[0]));
    uart_tx #(.NB_DATA(8), .NB_STOP(1), .PARITY(1)) u1 (.i_clk(clk), .i_reset_n(rst_n), .i_tick(tick),
        .i_tx_start(start[1]), .i_tx_data(data), .o_tx(tx[1]), .o_tx_busy(busy[1]), .o_tx_done(done[1]));
    uart_tx #(.NB_DATA(8), .NB_STOP(1), .PARITY(2)) u2 (.i_clk(clk), .i_reset_n(rst_n), .i_tick(tick),
        .i_tx_start(start[2]), .i_tx_data(data), .o_tx(tx[2]), .o_tx_busy(busy[2]), .o_tx_done(done[2]));
    uart_tx #(.NB_DATA(8), .NB_STOP(2), .PARITY(0)) u3 (.i_clk(clk), .i_reset_n(rst_n), .i_tick(tick),
        .i_tx_start(start[3]), .i_tx_data(data), .o_tx(tx[3]), .o_tx_busy(busy[3]), .o_tx_done(done[3]));

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (tick) samp[k].push_back(tx[k]);
            if (done[k]) dq[k].push_back(samp[k].size());
        end
    end

    function automatic int nst(input int k);
        return k == 3 ? 2 : 1;
    endfunction

    function automatic int pm(input int k);
        return k == 1 ? 1 : (k == 2 ? 2 : 0);
    endfunction

    function automatic int flen(input int k);
        return 16 * (1 + 8 + (pm(k) != 0 ? 1 : 0) + nst(k));
    endfunction

    function automatic bq_t frame(input int k, input logic [7:0] d);
        bq_t bits;
        bq_t e;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pm(k) != 0) bits.push_back((^d) ^ (pm(k) == 2));
        for (int s = 0; s < nst(k); s++) bits.push_back(1'b1);
        foreach (bits[i]) repeat (16) e.push_back(bits[i]);
        return e;
    endfunction

    function automatic int first_diff(input int k, input int b, input bq_t e, output logic got, output logic want);
        int n;
        n = samp[k].size() - b;
        got = 1'bx;
        want = 1'bx;
        for (int j = 0; j < n; j++) begin
            want = j < e.size() ? e[j] : 1'b1;
            got = samp[k][b + j];
            if (got !== want) return j;
        end
        if (n < e.size()) begin
            got = 1'bx;
            want = e[n];
            return n;
        end
        return -1;
    endfunction

    task automatic launch(input logic [3:0] m, input logic [7:0] d, input bit rel);
        do @(negedge clk); while (tick);
        if (rel) rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            base[k] = samp[k].size();
            dbase[k] = dq[k].size();
        end
        start = m;
        data = d;
        @(negedge clk);
        start = '0;
    endtask

    task automatic run(input int n, input bit scr);
        repeat (n) begin
            @(negedge clk);
            if (scr && $urandom_range(0, 3) == 0) data = 8'($urandom);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 0;
        #1;
        checks++;
        if (tx !== 4'hF || busy !== 4'h0 || done !== 4'h0) begin
            errors++;
            $display("FAIL reset_state: tx %b busy %b done %b, required 1111 0000 0000", tx, busy, done);
        end
        repeat (3) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_frames();
        logic [7:0] dl[$];
        logic [3:0] m;
        dl = '{8'h55, 8'hA5, 8'h00};
        for (int i = 0; i < 6; i++) dl.push_back(8'($urandom));
        foreach (dl[i]) begin
            m = i < 3 ? 4'hF : 4'($urandom_range(1, 15));
            launch(m, dl[i], 0);
            checks++;
            if (busy !== m || tx !== ~m) begin
                errors++;
                $display("FAIL first_start data %02h: busy %b tx %b, required %b %b", dl[i], busy, tx, m, ~m);
            end
            run(900, 1);
            for (int k = 0; k < 4; k++) begin
                bq_t e;
                logic g, w;
                int ix;
                e.delete();
                if (m[k]) e = frame(k, dl[i]);
                ix = first_diff(k, base[k], e, g, w);
                checks++;
                if (ix >= 0) begin
                    errors++;
                    $display("FAIL frame_line u%0d data %02h: tick %0d got %b required %b", k, dl[i], ix, g, w);
                end
                checks++;
                if (dq[k].size() - dbase[k] != int'(m[k])) begin
                    errors++;
                    $display("FAIL frame_done_count u%0d: got %0d required %0d", k, dq[k].size() - dbase[k], m[k]);
                end
                if (m[k] && dq[k].size() > dbase[k]) begin
                    checks++;
                    if (dq[k][dbase[k]] - base[k] != flen(k)) begin
                        errors++;
                        $display("FAIL frame_done_pos u%0d: got %0d ticks required %0d", k, dq[k][dbase[k]] - base[k], flen(k));
                    end
                end
            end
            if (dl[i] == 8'hA5 && i < 3) begin
                checks++;
                if (samp[1][base[1] + 152] !== 1'b0 || samp[2][base[2] + 152] !== 1'b1) begin
                    errors++;
                    $display("FAIL parity_a5: even %b odd %b, required 0 1", samp[1][base[1] + 152], samp[2][base[2] + 152]);
                end
            end
            checks++;
            if (busy !== 4'h0 || tx !== 4'hF) begin
                errors++;
                $display("FAIL idle_after: busy %b tx %b, required 0000 1111", busy, tx);
            end
        end
    endtask

    task automatic test_ignore();
        launch(4'hF, 8'h55, 0);
        run(200, 0);
        data = 8'h3C;
        start = 4'hF;
        @(negedge clk);
        start = '0;
        run(700, 0);
        for (int k = 0; k < 4; k++) begin
            bq_t e;
            logic g, w;
            int ix;
            e = frame(k, 8'h55);
            ix = first_diff(k, base[k], e, g, w);
            checks++;
            if (ix >= 0) begin
                errors++;
                $display("FAIL ignore_line u%0d: tick %0d got %b required %b", k, ix, g, w);
            end
            checks++;
            if (dq[k].size() - dbase[k] != 1) begin
                errors++;
                $display("FAIL ignore_done_count u%0d: got %0d required 1", k, dq[k].size() - dbase[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            int t;
            bit hit;
            t = 0;
            hit = 0;
            launch(4'(1 << k), 8'h12, 0);
            while (t < 1000 && !hit) begin
                @(negedge clk);
                t++;
                hit = done[k];
            end
            if (!hit) begin
                checks++;
                errors++;
                $display("FAIL b2b_timeout u%0d: no done after %0d cycles, required within 1000", k, t);
            end
            start[k] = 1'b1;
            data = 8'h34;
            checks++;
            if (tx[k] !== 1'b1 || busy[k] !== 1'b0) begin
                errors++;
                $display("FAIL b2b_done_cycle u%0d: tx %b busy %b, required 1 0", k, tx[k], busy[k]);
            end
            @(negedge clk);
            start = '0;
            run(900, 1);
            for (int j = 0; j < 4; j++) begin
                bq_t e, f;
                logic g, w;
                int ix;
                e.delete();
                if (j == k) begin
                    e = frame(j, 8'h12);
                    f = frame(j, 8'h34);
                    foreach (f[x]) e.push_back(f[x]);
                end
                ix = first_diff(j, base[j], e, g, w);
                checks++;
                if (ix >= 0) begin
                    errors++;
                    $display("FAIL b2b_line run%0d u%0d: tick %0d got %b required %b", k, j, ix, g, w);
                end
                checks++;
                if (dq[j].size() - dbase[j] != (j == k ? 2 : 0)) begin
                    errors++;
                    $display("FAIL b2b_done_count run%0d u%0d: got %0d required %0d", k, j, dq[j].size() - dbase[j], j == k ? 2 : 0);
                end
            end
            if (dq[k].size() - dbase[k] == 2) begin
                checks++;
                if (dq[k][dbase[k] + 1] - base[k] != 2 * flen(k)) begin
                    errors++;
                    $display("FAIL b2b_second_done u%0d: got %0d ticks required %0d", k, dq[k][dbase[k] + 1] - base[k], 2 * flen(k));
                end
            end
        end
    endtask

    task automatic test_abort();
        int t;
        t = 0;
        launch(4'hF, 8'h00, 0);
        while (t < 400 && samp[0].size() - base[0] < 56) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (samp[0].size() - base[0] < 56) begin
            errors++;
            $display("FAIL abort_reach: got %0d ticks required 56", samp[0].size() - base[0]);
        end
        #1 rst_n = 0;
        #1;
        checks++;
        if (tx !== 4'hF || busy !== 4'h0 || done !== 4'h0) begin
            errors++;
            $display("FAIL abort_async: tx %b busy %b done %b, required 1111 0000 0000", tx, busy, done);
        end
        repeat (4) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (dq[k].size() != dbase[k]) begin
                errors++;
                $display("FAIL abort_no_done u%0d: got %0d pulses required 0", k, dq[k].size() - dbase[k]);
            end
        end
        launch(4'hF, 8'hFF, 1);
        checks++;
        if (busy !== 4'hF || tx !== 4'h0) begin
            errors++;
            $display("FAIL abort_restart: busy %b tx %b, required 1111 0000", busy, tx);
        end
        run(900, 1);
        for (int k = 0; k < 4; k++) begin
            bq_t e;
            logic g, w;
            int ix;
            e = frame(k, 8'hFF);
            ix = first_diff(k, base[k], e, g, w);
            checks++;
            if (ix >= 0) begin
                errors++;
                $display("FAIL abort_clean_line u%0d: tick %0d got %b required %b", k, ix, g, w);
            end
            checks++;
            if (dq[k].size() - dbase[k] != 1) begin
                errors++;
                $display("FAIL abort_clean_done u%0d: got %0d required 1", k, dq[k].size() - dbase[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_ignore();
        test_back_to_back();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter NB_DATA, default 8, number of data bits per frame.
REQ-002 SHALL have parameter NB_STOP, default 1, number of stop bits (1 or 2).
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 SHALL have port i_clk, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port i_reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port i_tick, input, 1, one-cycle enable at 16x baud, from the external baud generator.
REQ-007 SHALL have port i_tx_start, input, 1, request to send i_tx_data.
REQ-008 SHALL have port i_tx_data, input, NB_DATA, byte to send.
REQ-009 SHALL have port o_tx, output, 1, serial line, idle high.
REQ-010 SHALL have port o_tx_busy, output, 1, high while a frame is in progress.
REQ-011 SHALL have port o_tx_done, output, 1, one-cycle pulse at frame completion.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY==0.
REQ-013 IDLE: o_tx=1, o_tx_busy=0; on i_tx_start=1, SHALL latch i_tx_data into a shift register, clear tick and bit counters, and go to START next cycle, independent of i_tick.
REQ-014 START: o_tx=0 for exactly 16 i_tick pulses, then go to DATA.
REQ-015 DATA: o_tx = shift register LSB; after 16 ticks, shift right by one; after NB_DATA bits, go to PARITY or STOP; LSB is sent first.
REQ-016 PARITY: o_tx = XOR of latched data (even) or its inverse (odd), held for 16 ticks.
REQ-017 STOP: o_tx=1 for 16*NB_STOP ticks; on the last tick go to IDLE.
REQ-018 o_tx SHALL be registered: no combinational path from any input to o_tx.
REQ-019 o_tx_busy SHALL be 1 in every non-IDLE state, including the first START cycle.
REQ-020 o_tx_done SHALL be registered: asserted for one cycle, coinciding with the first IDLE cycle after STOP.
REQ-021 i_tx_start while busy SHALL be ignored; no queuing, and the latched data is unchanged.
REQ-022 i_tx_start in the same cycle o_tx_done is high SHALL be accepted, giving back-to-back frames with no extra idle bit.
REQ-023 i_tx_data changes after the start cycle SHALL NOT affect the frame in flight.
REQ-024 Tick counter SHALL be 5 bits wide (to cover 32 for NB_STOP=2); bit counter SHALL be ceil(log2(NB_DATA+1)) bits wide; no wrap-around within a frame.
REQ-025 Total frame SHALL equal 16*(1+NB_DATA+(PARITY!=0)+NB_STOP) ticks, measured from the first START tick.
REQ-026 An unreachable state encoding SHALL return to IDLE with o_tx=1.

Reset
REQ-027 On i_reset_n=0, asynchronously: state=IDLE, o_tx=1, o_tx_busy=0, o_tx_done=0, counters=0, shift register=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately; o_tx goes high with no partial stop bit and no o_tx_done pulse.
REQ-029 After reset deassertion, the first i_tx_start SHALL be accepted on the first clock edge.

Structure
REQ-030 Shared package uart_pkg SHALL hold the state encodings, the OVERSAMPLE=16 constant and the parity mode codes, for use by both uart_tx and the receiver.
REQ-031 SHALL be a single module with no sub-module; the baud tick generator stays external and shared with the receiver.

Verification
REQ-032 NB_DATA=8, PARITY=0, send 0x55 -> o_tx sequence 0,1,0,1,0,1,0,1,0,1, each bit 16 ticks; one o_tx_done pulse; busy low after.
REQ-033 PARITY=1, send 0xA5 -> parity bit 0; PARITY=2, send 0xA5 -> parity bit 1; frame length 16*11 ticks.
REQ-034 i_tx_start with 0x3C during a 0x55 frame -> line still carries 0x55 only; no second frame and no extra done pulse.
REQ-035 Start 0x12, then restart 0x34 in the o_tx_done cycle -> two contiguous frames; stop bit of 0x12 followed directly by the start bit of 0x34.
REQ-036 i_reset_n low during the 3rd data bit -> o_tx=1 and busy=0 asynchronously, no done pulse; next start of 0xFF sends a clean frame.
REQ-037 NB_STOP=2, send 0x00 -> stop high for 32 ticks before o_tx_done.
